icache_sa: RTL and testbench

Parametrised set-associative instruction cache for the fetch unit. It has an integrated refill FSM, a request/valid handshake to IRAM, and a per-set round-robin replacement policy with invalid-way priority. The block adds a sequential flush (fence.i) and a saturating miss counter. It sits between the PC register and the decode stage. On a miss it stalls the fetch unit until the refill block returns, and forwards the requested instruction in the same cycle the block arrives.

---
 rtl/icache_sa.sv | 227 ++++++++++++++++++++++
 tb/tb_icache_sa.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_sa.sv
// Set-associative instruction cache with a blocking refill FSM, per-set round-robin
// replacement (invalid ways first), sequential flush and a saturating miss counter.
module icache_sa #(
   parameter int PC_W    = 32,
   parameter int INSTR_W = 32,
   parameter int BLOCK_W = 128,
   parameter int SETS    = 16,
   parameter int WAYS    = 4,
   parameter int CNT_W   = 32
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               pc_valid_i,
   input  logic [PC_W-1:0]    pc_i,
   input  logic               flush_i,
   output logic               instr_valid_o,
   output logic [INSTR_W-1:0] fetched_inst_o,
   output logic               stall_o,
   output logic               flush_busy_o,
   output logic               mem_req_o,
   output logic [PC_W-1:0]    mem_addr_o,
   input  logic               mem_valid_i,
   input  logic [BLOCK_W-1:0] mem_block_i,
   output logic [CNT_W-1:0]   miss_cnt_o
);

   localparam int OFF_W  = $clog2(BLOCK_W / 8);
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_W  = PC_W - OFF_W - IDX_W;
   localparam int WORDS  = BLOCK_W / INSTR_W;
   localparam int WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_FLUSH
   } state_t;

   // Tag/valid/data storage and per-set replacement pointer
   logic [WAYS-1:0]    valid_q    [SETS];
   logic [WAY_W-1:0]   rr_q       [SETS];
   logic [TAG_W-1:0]   tag_mem_q  [SETS][WAYS];
   logic [BLOCK_W-1:0] data_mem_q [SETS][WAYS];

   state_t             state_q, state_d;
   logic               flush_pend_q, flush_pend_d;
   logic [IDX_W-1:0]   fcnt_q, fcnt_d;
   logic [PC_W-1:0]    blk_addr_q, blk_addr_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [WSEL_W-1:0]  wsel_q, wsel_d;
   logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

   logic [IDX_W-1:0]   pc_idx;
   logic [TAG_W-1:0]   pc_tag;
   logic [WSEL_W-1:0]  pc_wsel;
   logic [WAYS-1:0]    hit_vec;
   logic               hit;
   logic [BLOCK_W-1:0] hit_block;
   logic [WAY_W-1:0]   victim;
   logic               all_valid;
   logic [WAY_W-1:0]   rr_next;
   logic               fill;
   logic               unused_pc_lsb;

   assign pc_idx        = pc_i[OFF_W +: IDX_W];
   assign pc_tag        = pc_i[PC_W-1 -: TAG_W];
   assign unused_pc_lsb = ^pc_i[1:0];

   generate
      if (WORDS > 1) begin : g_wsel
         assign pc_wsel = pc_i[OFF_W-1:2];
      end else begin : g_wsel_single
         assign pc_wsel = '0;
      end
   endgenerate

   // Byte k lives at mem bits [8k+7:8k] with bit 8k as its MSB; words assemble little-endian
   function automatic logic [INSTR_W-1:0] get_word(input logic [BLOCK_W-1:0] blk,
                                                   input logic [WSEL_W-1:0]  w);
      logic [INSTR_W-1:0] r;
      r = '0;
      for (int b = 0; b < 4; b++) begin
         for (int j = 0; j < 8; j++) begin
            r[8*b + 7 - j] = blk[8*(4*int'(w) + b) + j];
         end
      end
      return r;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < WAYS; gi++) begin : g_hit
         assign hit_vec[gi] = valid_q[pc_idx][gi] && (tag_mem_q[pc_idx][gi] == pc_tag);
      end
   endgenerate

   assign hit = |hit_vec;

   always_comb begin
      hit_block = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (hit_vec[w]) hit_block = hit_block | data_mem_q[pc_idx][w];
      end
   end

   // Descending scan so the lowest-index invalid way wins; rr pointer only when set is full
   always_comb begin
      victim    = rr_q[idx_q];
      all_valid = &valid_q[idx_q];
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[idx_q][w]) victim = WAY_W'(w);
      end
      rr_next = (rr_q[idx_q] == WAY_W'(WAYS - 1)) ? '0 : rr_q[idx_q] + 1'b1;
   end

   always_comb begin
      state_d        = state_q;
      flush_pend_d   = flush_pend_q;
      fcnt_d         = fcnt_q;
      blk_addr_d     = blk_addr_q;
      idx_d          = idx_q;
      tag_d          = tag_q;
      wsel_d         = wsel_q;
      miss_cnt_d     = miss_cnt_q;
      instr_valid_o  = 1'b0;
      fetched_inst_o = '0;
      mem_req_o      = 1'b0;
      mem_addr_o     = '0;
      fill           = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (flush_i) begin
               state_d = ST_FLUSH;
               fcnt_d  = '0;
            end else if (pc_valid_i) begin
               if (hit) begin
                  instr_valid_o  = 1'b1;
                  fetched_inst_o = get_word(hit_block, pc_wsel);
               end else begin
                  state_d    = ST_WAIT;
                  blk_addr_d = {pc_i[PC_W-1:OFF_W], {OFF_W{1'b0}}};
                  idx_d      = pc_idx;
                  tag_d      = pc_tag;
                  wsel_d     = pc_wsel;
                  miss_cnt_d = (&miss_cnt_q) ? miss_cnt_q : miss_cnt_q + 1'b1;
               end
            end
         end

         ST_WAIT: begin
            mem_req_o  = 1'b1;
            mem_addr_o = blk_addr_q;
            if (flush_i) flush_pend_d = 1'b1;
            if (mem_valid_i) begin
               fill           = 1'b1;
               instr_valid_o  = 1'b1;
               fetched_inst_o = get_word(mem_block_i, wsel_q);
               flush_pend_d   = 1'b0;
               fcnt_d         = '0;
               state_d        = (flush_pend_q || flush_i) ? ST_FLUSH : ST_IDLE;
            end
         end

         ST_FLUSH: begin
            fcnt_d = fcnt_q + 1'b1;
            if (fcnt_q == IDX_W'(SETS - 1)) state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign flush_busy_o = (state_q == ST_FLUSH) || flush_pend_q;
   assign stall_o      = (pc_valid_i && !instr_valid_o) || flush_busy_o;
   assign miss_cnt_o   = miss_cnt_q;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q      <= ST_IDLE;
         flush_pend_q <= 1'b0;
         fcnt_q       <= '0;
         blk_addr_q   <= '0;
         idx_q        <= '0;
         tag_q        <= '0;
         wsel_q       <= '0;
         miss_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         flush_pend_q <= flush_pend_d;
         fcnt_q       <= fcnt_d;
         blk_addr_q   <= blk_addr_d;
         idx_q        <= idx_d;
         tag_q        <= tag_d;
         wsel_q       <= wsel_d;
         miss_cnt_q   <= miss_cnt_d;
      end
   end

   generate
      for (gi = 0; gi < SETS; gi++) begin : g_set
         always_ff @(posedge clk) begin
            if (!nrst) begin
               valid_q[gi] <= '0;
               rr_q[gi]    <= '0;
            end else if (state_q == ST_FLUSH && fcnt_q == IDX_W'(gi)) begin
               valid_q[gi] <= '0;
               rr_q[gi]    <= '0;
            end else if (fill && idx_q == IDX_W'(gi)) begin
               valid_q[gi][victim] <= 1'b1;
               if (all_valid) rr_q[gi] <= rr_next;
            end
         end
      end
   endgenerate

   // Payload arrays carry no reset; the valid bits alone qualify them
   always_ff @(posedge clk) begin
      if (fill && nrst) begin
         data_mem_q[idx_q][victim] <= mem_block_i;
         tag_mem_q[idx_q][victim]  <= tag_q;
      end
   end

endmodule

// File: tb/tb_icache_sa.sv
// Directed bench for icache_sa: stimulus pushes expected fetches into a queue,
// a negedge monitor pops and compares whenever instr_valid is seen.
module tb_icache_sa;

   logic         clk = 1'b0;
   logic         nrst = 1'b0;
   logic         pc_valid = 1'b0;
   logic [31:0]  pc = '0;
   logic         flush = 1'b0;
   logic         mem_valid = 1'b0;
   logic [127:0] mem_block = '0;

   logic         instr_valid, stall, flush_busy, mem_req;
   logic [31:0]  fetched_inst, mem_addr, miss_cnt;

   logic         sat_unused_iv, sat_unused_stall, sat_unused_busy, sat_unused_req;
   logic [31:0]  sat_unused_inst, sat_unused_addr;
   logic [3:0]   sat_miss;

   icache_sa u_dut (
      .clk(clk), .nrst(nrst), .pc_valid_i(pc_valid), .pc_i(pc), .flush_i(flush),
      .instr_valid_o(instr_valid), .fetched_inst_o(fetched_inst), .stall_o(stall),
      .flush_busy_o(flush_busy), .mem_req_o(mem_req), .mem_addr_o(mem_addr),
      .mem_valid_i(mem_valid), .mem_block_i(mem_block), .miss_cnt_o(miss_cnt)
   );

   icache_sa #(.CNT_W(4)) u_sat (
      .clk(clk), .nrst(nrst), .pc_valid_i(pc_valid), .pc_i(pc), .flush_i(flush),
      .instr_valid_o(sat_unused_iv), .fetched_inst_o(sat_unused_inst),
      .stall_o(sat_unused_stall), .flush_busy_o(sat_unused_busy),
      .mem_req_o(sat_unused_req), .mem_addr_o(sat_unused_addr),
      .mem_valid_i(mem_valid), .mem_block_i(mem_block), .miss_cnt_o(sat_miss)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } txn_t;
   txn_t exp_q[$];

   // Memory image: byte k of block at base = {base[11:8]^base[7:4]^1, k}
   function automatic logic [7:0] mem_byte(input logic [31:0] base, input int k);
      logic [3:0] hi;
      logic [3:0] lo;
      hi = base[11:8] ^ base[7:4] ^ 4'h1;
      lo = 4'(k);
      return {hi, lo};
   endfunction

   function automatic logic [127:0] mk_block(input logic [31:0] base);
      logic [127:0] blk;
      logic [7:0]   by;
      blk = '0;
      for (int k = 0; k < 16; k++) begin
         by = mem_byte(base, k);
         for (int j = 0; j < 8; j++) blk[8*k + j] = by[7 - j];
      end
      return blk;
   endfunction

   function automatic logic [31:0] exp_word(input logic [31:0] a);
      logic [31:0] base;
      int w;
      base = {a[31:4], 4'h0};
      w = int'(a[3:2]);
      return {mem_byte(base, 4*w + 3), mem_byte(base, 4*w + 2),
              mem_byte(base, 4*w + 1), mem_byte(base, 4*w)};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      txn_t t;
      if (nrst) begin
         if (instr_valid) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("[TB] FAIL unexpected_instr_valid: got inst 0x%0h, expected no output",
                        fetched_inst);
            end else begin
               t = exp_q.pop_front();
               chk("fetched_inst", {32'h0, fetched_inst}, {32'h0, t.inst});
               $display("[TB] fetch pc=0x%08h inst=0x%08h", t.pc, fetched_inst);
            end
         end else begin
            chk("inst_zero_when_idle", {32'h0, fetched_inst}, 64'h0);
         end
      end
   end

   // One fetch; a miss holds mem_req for dly cycles before the block returns
   task automatic fetch(input logic [31:0] a, input bit miss, input logic [31:0] inst,
                        input int dly);
      txn_t t;
      t.pc = a;
      t.inst = inst;
      exp_q.push_back(t);
      pc_valid = 1'b1;
      pc = a;
      @(negedge clk);
      chk($sformatf("stall_%08h", a), {63'h0, stall}, {63'h0, miss});
      if (miss) begin
         chk("mem_req_detect_cycle", {63'h0, mem_req}, 64'h0);
         for (int d = 0; d < dly; d++) begin
            @(posedge clk); #1;
            pc = a ^ 32'h8;
            @(negedge clk);
            if (d == 0) begin
               chk("mem_req_wait", {63'h0, mem_req}, 64'h1);
               chk("mem_addr", {32'h0, mem_addr}, {32'h0, a[31:4], 4'h0});
            end
         end
         @(posedge clk); #1;
         mem_valid = 1'b1;
         mem_block = mk_block({a[31:4], 4'h0});
         @(negedge clk);
         chk("forward_valid", {63'h0, instr_valid}, 64'h1);
      end else begin
         chk("hit_valid", {63'h0, instr_valid}, 64'h1);
      end
      @(posedge clk); #1;
      mem_valid = 1'b0;
      mem_block = '0;
      pc_valid = 1'b0;
   endtask

   task automatic do_reset();
      nrst = 1'b0;
      pc_valid = 1'b0;
      flush = 1'b0;
      mem_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 nrst = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
   endtask

   task automatic count_busy(input logic [31:0] probe_pc, output int busy_n, output int bad_stall);
      busy_n = 0;
      bad_stall = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (flush_busy) begin
            busy_n++;
            if (!stall) bad_stall++;
         end
         @(posedge clk); #1;
         if (c == 15) pc_valid = 1'b0;
         else if (c < 15) begin
            pc_valid = (probe_pc != 32'h0);
            pc = probe_pc;
         end
      end
   endtask

   logic [31:0] tab_a[18] = '{32'h004, 32'h108, 32'h20C, 32'h300, 32'h000, 32'h104, 32'h208,
                              32'h30C, 32'h404, 32'h508, 32'h200, 32'h304, 32'h40C, 32'h500,
                              32'h008, 32'h10C, 32'h400, 32'h604};
   bit          tab_m[18] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 1};
   logic [31:0] tab2_a[7] = '{32'h400, 32'h504, 32'h608, 32'h70C, 32'h800, 32'h500, 32'h404};
   bit          tab2_m[7] = '{1, 1, 1, 1, 1, 0, 1};

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_n;
      int bad_stall;

      do_reset();
      @(negedge clk);
      chk("rst_instr_valid", {63'h0, instr_valid}, 64'h0);
      chk("rst_stall", {63'h0, stall}, 64'h0);
      chk("rst_flush_busy", {63'h0, flush_busy}, 64'h0);
      chk("rst_mem_req", {63'h0, mem_req}, 64'h0);
      chk("rst_mem_addr", {32'h0, mem_addr}, 64'h0);
      chk("rst_miss_cnt", {32'h0, miss_cnt}, 64'h0);
      @(posedge clk); #1;

      // Cold miss, forwarded data, then hits in the same block
      fetch(32'h0000_0104, 1, 32'h0706_0504, 3);
      chk("miss_cnt_cold", {32'h0, miss_cnt}, 64'h1);
      fetch(32'h0000_0104, 0, 32'h0706_0504, 0);
      fetch(32'h0000_010C, 0, 32'h1F1E_1D1C ^ 32'h1010_1010, 0);
      chk("miss_cnt_after_hits", {32'h0, miss_cnt}, 64'h1);

      // Set-0 conflicts: invalid-first fill, then round-robin eviction
      do_reset();
      for (int i = 0; i < 18; i++) fetch(tab_a[i], tab_m[i], exp_word(tab_a[i]), 1);
      chk("miss_cnt_conflict", {32'h0, miss_cnt}, 64'd9);

      // Flush from IDLE with a cached pc presented; lookups must stay suppressed
      flush = 1'b1;
      pc_valid = 1'b1;
      pc = 32'h500;
      @(negedge clk);
      chk("flush_pulse_busy", {63'h0, flush_busy}, 64'h0);
      chk("flush_pulse_stall", {63'h0, stall}, 64'h1);
      @(posedge clk); #1;
      flush = 1'b0;
      count_busy(32'h500, busy_n, bad_stall);
      chk("flush_busy_cycles", 64'(busy_n), 64'd16);
      chk("flush_stall_gaps", 64'(bad_stall), 64'd0);
      for (int i = 0; i < 7; i++) fetch(tab2_a[i], tab2_m[i], exp_word(tab2_a[i]), 1);

      // Flush arriving one cycle into a refill
      begin
         txn_t t;
         t.pc = 32'h904;
         t.inst = exp_word(32'h904);
         exp_q.push_back(t);
      end
      pc_valid = 1'b1;
      pc = 32'h904;
      @(negedge clk);
      chk("fw_miss_stall", {63'h0, stall}, 64'h1);
      @(posedge clk); #1;
      flush = 1'b1;
      @(negedge clk);
      chk("fw_mem_req", {63'h0, mem_req}, 64'h1);
      chk("fw_busy_pulse", {63'h0, flush_busy}, 64'h0);
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      chk("fw_busy_pending", {63'h0, flush_busy}, 64'h1);
      @(posedge clk); #1;
      mem_valid = 1'b1;
      mem_block = mk_block(32'h900);
      @(negedge clk);
      chk("fw_forward", {63'h0, instr_valid}, 64'h1);
      chk("fw_busy_refill", {63'h0, flush_busy}, 64'h1);
      @(posedge clk); #1;
      mem_valid = 1'b0;
      pc_valid = 1'b0;
      count_busy(32'h0, busy_n, bad_stall);
      chk("fw_flush_cycles", 64'(busy_n), 64'd16);
      fetch(32'h904, 1, exp_word(32'h904), 1);

      // Reset in the middle of a refill; the late block must be ignored
      pc_valid = 1'b1;
      pc = 32'hA08;
      @(negedge clk);
      chk("rm_stall", {63'h0, stall}, 64'h1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rm_mem_req", {63'h0, mem_req}, 64'h1);
      @(posedge clk); #1;
      nrst = 1'b0;
      @(posedge clk); #1;
      nrst = 1'b1;
      pc_valid = 1'b0;
      mem_valid = 1'b1;
      mem_block = mk_block(32'hA00);
      @(negedge clk);
      chk("rm_mem_req_dropped", {63'h0, mem_req}, 64'h0);
      chk("rm_miss_cnt", {32'h0, miss_cnt}, 64'h0);
      chk("rm_no_forward", {63'h0, instr_valid}, 64'h0);
      @(posedge clk); #1;
      mem_valid = 1'b0;
      mem_block = '0;
      fetch(32'hA08, 1, exp_word(32'hA08), 2);
      chk("rm_miss_cnt_after", {32'h0, miss_cnt}, 64'h1);

      // Saturating counter on the 4-bit instance
      do_reset();
      for (int i = 0; i < 20; i++) begin
         fetch(32'h1000 + 32'(i) * 32'h10, 1, exp_word(32'h1000 + 32'(i) * 32'h10), 1);
         if (i == 13) chk("sat_cnt_14", {60'h0, sat_miss}, 64'd14);
      end
      chk("sat_cnt_stuck", {60'h0, sat_miss}, 64'hF);
      chk("wide_cnt_20", {32'h0, miss_cnt}, 64'd20);

      repeat (2) @(posedge clk);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
